// File: rtl/pwm_pkg.sv
// Shared PWM definitions: mode encodings and default datapath widths.
package pwm_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int STEP_W_DEF = 12;

    typedef enum logic [1:0] {
        PWM_MODE_OFF    = 2'b00,
        PWM_MODE_FIXED  = 2'b01,
        PWM_MODE_BREATH = 2'b10,
        PWM_MODE_RSVD   = 2'b11
    } pwm_mode_e;

    // Reserved mode behaves as off, so only these two ever drive the counter.
    function automatic logic mode_running(input logic [1:0] mode);
        return (mode == PWM_MODE_FIXED) || (mode == PWM_MODE_BREATH);
    endfunction

endpackage

// File: rtl/pwm_core_if.sv
// Configuration inputs and waveform outputs of the PWM core.
interface pwm_core_if
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) ();

    logic [1:0]        pwm_mode;
    logic [CNT_W-1:0]  pwm_period;
    logic [CNT_W-1:0]  pwm_threshold1;
    logic [CNT_W-1:0]  pwm_threshold2;
    logic [STEP_W-1:0] pwm_step;
    logic              pwm;
    logic              period_end;

    modport master (
        output pwm_mode, pwm_period, pwm_threshold1, pwm_threshold2, pwm_step,
        input  pwm, period_end
    );

    modport slave (
        input  pwm_mode, pwm_period, pwm_threshold1, pwm_threshold2, pwm_step,
        output pwm, period_end
    );

endinterface

// File: rtl/pwm_breath_ramp.sv
// Breathing duty ramp: bounces duty between lo and hi by step once per update.
module pwm_breath_ramp
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  lo,
    input  logic [CNT_W-1:0]  hi,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic              update,
    output logic [CNT_W-1:0]  duty
);

    logic             up;
    logic             hold;
    logic [CNT_W-1:0] step_c;
    logic [CNT_W:0]   sum;
    logic [CNT_W:0]   floor_lvl;
    logic [CNT_W-1:0] diff;

    // One extra bit on the comparisons keeps duty+step and lo+step from wrapping.
    assign step_c    = {{(CNT_W-STEP_W){1'b0}}, step};
    assign sum       = {1'b0, duty} + {1'b0, step_c};
    assign floor_lvl = {1'b0, lo} + {1'b0, step_c};
    assign diff      = duty - step_c;
    assign hold      = (lo >= hi) || (step == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            up   <= 1'b1;
        end else if (load) begin
            duty <= lo;
            up   <= 1'b1;
        end else if (update) begin
            if (hold) begin
                duty <= lo;
                up   <= 1'b1;
            end else if (up) begin
                if (sum >= {1'b0, hi}) begin
                    duty <= hi;
                    up   <= 1'b0;
                end else begin
                    duty <= sum[CNT_W-1:0];
                end
            end else begin
                if ({1'b0, duty} <= floor_lvl) begin
                    duty <= lo;
                    up   <= 1'b1;
                end else begin
                    duty <= diff;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_core.sv
// PWM core: period counter with shadowed settings, fixed or breathing duty.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int STEP_W = STEP_W_DEF
) (
    input  logic       s_axi_aclk_i,
    input  logic       s_axi_aresetn_i,
    pwm_core_if.slave  bus
);

    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period_sh;
    logic [CNT_W-1:0]  th1_sh;
    logic [CNT_W-1:0]  th2_sh;
    logic [STEP_W-1:0] step_sh;
    logic [CNT_W-1:0]  ramp_duty;
    logic [CNT_W-1:0]  ramp_lo;
    logic [CNT_W-1:0]  duty;
    logic              active;
    logic              wrap;
    logic              pwm_q;

    // A mode change, an off mode or a zero period all park the counter at 0
    // and keep reloading the shadows, so the next real period starts clean.
    assign active  = (bus.pwm_mode == mode_q) && mode_running(mode_q) && (period_sh != '0);
    assign wrap    = active && (cnt == period_sh - CNT_W'(1));
    assign duty    = (mode_q == PWM_MODE_BREATH) ? ramp_duty : th1_sh;
    assign ramp_lo = active ? th1_sh : bus.pwm_threshold1;

    pwm_breath_ramp #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W)
    ) u_ramp (
        .clk    (s_axi_aclk_i),
        .rst    (s_axi_aresetn_i),
        .lo     (ramp_lo),
        .hi     (th2_sh),
        .step   (step_sh),
        .load   (!active),
        .update (wrap && (mode_q == PWM_MODE_BREATH)),
        .duty   (ramp_duty)
    );

    always_ff @(posedge s_axi_aclk_i) begin
        if (s_axi_aresetn_i) begin
            mode_q    <= PWM_MODE_OFF;
            cnt       <= '0;
            period_sh <= '0;
            th1_sh    <= '0;
            th2_sh    <= '0;
            step_sh   <= '0;
            pwm_q     <= 1'b0;
        end else begin
            mode_q <= bus.pwm_mode;
            pwm_q  <= active && (cnt < duty);
            if (!active || wrap) begin
                cnt       <= '0;
                period_sh <= bus.pwm_period;
                th1_sh    <= bus.pwm_threshold1;
                th2_sh    <= bus.pwm_threshold2;
                step_sh   <= bus.pwm_step;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pwm        = pwm_q;
    assign bus.period_end = wrap && !s_axi_aresetn_i;

endmodule

// File: tb/tb_pwm_core.sv
// Bench for pwm_core: directed waveform checks plus randomized run against a cycle reference model.
module tb_pwm_core;
    import pwm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pwm_core_if #(.CNT_W(32), .STEP_W(12)) bus ();

    pwm_core #(.CNT_W(32), .STEP_W(12)) dut (
        .s_axi_aclk_i    (clk),
        .s_axi_aresetn_i (rst),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    // Reference model state, in plain integers.
    int     m_mode;
    longint m_cnt, m_per, m_t1, m_t2, m_step, m_duty;
    bit     m_up;
    bit     e_pwm;

    function automatic bit m_run();
        return (int'(bus.pwm_mode) == m_mode) && (m_mode == 1 || m_mode == 2) && (m_per != 0);
    endfunction

    function automatic bit e_pe();
        return !rst && m_run() && (m_cnt == m_per - 1);
    endfunction

    task automatic m_load();
        m_per  = longint'(bus.pwm_period);
        m_t1   = longint'(bus.pwm_threshold1);
        m_t2   = longint'(bus.pwm_threshold2);
        m_step = longint'(bus.pwm_step);
    endtask

    task automatic m_breathe();
        if (m_t1 >= m_t2 || m_step == 0) begin
            m_duty = m_t1;
            m_up   = 1;
        end else if (m_up) begin
            m_duty = (m_duty + m_step < m_t2) ? m_duty + m_step : m_t2;
            if (m_duty == m_t2) m_up = 0;
        end else begin
            m_duty = (m_duty - m_step > m_t1) ? m_duty - m_step : m_t1;
            if (m_duty == m_t1) m_up = 1;
        end
    endtask

    task automatic m_edge();
        bit     run;
        longint d;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_per = 0; m_t1 = 0; m_t2 = 0; m_step = 0;
            m_duty = 0; m_up = 1; e_pwm = 0;
        end else begin
            run   = m_run();
            d     = (m_mode == 2) ? m_duty : m_t1;
            e_pwm = run && (m_cnt < d);
            if (!run) begin
                m_cnt = 0; m_load(); m_duty = m_t1; m_up = 1;
            end else if (m_cnt == m_per - 1) begin
                if (m_mode == 2) m_breathe();
                m_cnt = 0; m_load();
            end else begin
                m_cnt++;
            end
            m_mode = int'(bus.pwm_mode);
        end
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance model, then compare both outputs against it.
    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
        chk("model_pwm", longint'(bus.pwm), longint'(e_pwm));
        chk("model_period_end", longint'(bus.period_end), longint'(e_pe()));
    endtask

    task automatic drive(input int mode, input int per, input int t1, input int t2, input int st);
        bus.pwm_mode       = 2'(mode);
        bus.pwm_period     = 32'(per);
        bus.pwm_threshold1 = 32'(t1);
        bus.pwm_threshold2 = 32'(t2);
        bus.pwm_step       = 12'(st);
    endtask

    // Pass through off, then enter the mode; after this tick cnt is 0.
    task automatic start(input int mode, input int per, input int t1, input int t2, input int st);
        drive(0, per, t1, t2, st);
        tick();
        drive(mode, per, t1, t2, st);
        tick();
        chk("start_pwm_low", longint'(bus.pwm), 0);
    endtask

    task automatic fixed_pattern(input string tag, input int per, input int th, input int n);
        for (int k = 1; k <= n; k++) begin
            tick();
            chk({tag, "_pwm"}, longint'(bus.pwm), longint'(((k - 1) % per) < th));
            chk({tag, "_pe"}, longint'(bus.period_end), longint'((k % per) == per - 1));
        end
    endtask

    task automatic breath_highs(input string tag, input int per, input int exp_q[$]);
        int hi;
        foreach (exp_q[j]) begin
            hi = 0;
            for (int k = 0; k < per; k++) begin
                tick();
                hi += int'(bus.pwm);
            end
            chk(tag, hi, exp_q[j]);
        end
    endtask

    initial begin
        int h0, h1;
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("reset_pwm", longint'(bus.pwm), 0);
        chk("reset_period_end", longint'(bus.period_end), 0);
        rst = 1'b0;

        // Fixed duty 3 of 10, including start straight out of reset.
        drive(1, 10, 3, 0, 0);
        tick();
        chk("restart_pwm", longint'(bus.pwm), 0);
        fixed_pattern("fixed3", 10, 3, 30);

        // Duty extremes and zero period.
        start(1, 10, 0, 0, 0);
        fixed_pattern("fixed0", 10, 0, 20);
        start(1, 10, 15, 0, 0);
        fixed_pattern("fixed15", 10, 10, 20);
        start(1, 0, 5, 0, 0);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("per0_pwm", longint'(bus.pwm), 0);
            chk("per0_pe", longint'(bus.period_end), 0);
        end

        // Breathing ramps.
        start(2, 4, 1, 3, 1);
        breath_highs("breath_s1", 4, '{1, 2, 3, 2, 1, 2, 3});
        start(2, 4, 1, 3, 5);
        breath_highs("breath_s5", 4, '{1, 3, 1, 3});
        start(2, 4, 3, 3, 1);
        breath_highs("breath_flat", 4, '{3, 3, 3});

        // Mid-period threshold change only lands at the next period.
        start(1, 10, 3, 0, 0);
        h0 = 0; h1 = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 10) h0 += int'(bus.pwm);
            else         h1 += int'(bus.pwm);
            if (k == 2) drive(1, 10, 6, 0, 0);
        end
        chk("shadow_cur", h0, 3);
        chk("shadow_next", h1, 6);

        // Reset mid-period while high.
        start(1, 10, 3, 0, 0);
        tick();
        chk("pre_reset_high", longint'(bus.pwm), 1);
        rst = 1'b1;
        tick();
        chk("reset_forces_low", longint'(bus.pwm), 0);
        rst = 1'b0;
        tick();
        fixed_pattern("post_reset", 10, 3, 10);

        // Off mid-period, then back on.
        start(1, 10, 3, 0, 0);
        tick();
        drive(0, 10, 3, 0, 0);
        tick();
        chk("off_low", longint'(bus.pwm), 0);
        tick();
        chk("off_cnt_held", longint'(bus.period_end), 0);
        drive(1, 10, 3, 0, 0);
        tick();
        fixed_pattern("back_on", 10, 3, 10);

        // Randomized run against the model.
        drive(2, 6, 1, 5, 1);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(19) == 0) bus.pwm_mode = 2'($urandom_range(3));
            if ($urandom_range(9) == 0)  bus.pwm_period = 32'($urandom_range(9));
            if ($urandom_range(9) == 0)  bus.pwm_threshold1 = 32'($urandom_range(11));
            if ($urandom_range(9) == 0)  bus.pwm_threshold2 = 32'($urandom_range(11));
            if ($urandom_range(9) == 0)  bus.pwm_step = 12'($urandom_range(4));
            rst = ($urandom_range(79) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_core.md
PWM_CORE -- requirements
Module: pwm_core

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL have parameter CNT_W, default 32, giving the width of the counter, period and threshold.
REQ-003 SHALL have parameter STEP_W, default 12, giving the width of the breathing step.
REQ-004 s_axi_aclk_i  in  1  clock; all state updates on its rising edge.
REQ-005 s_axi_aresetn_i  in  1  synchronous active-high reset (despite the name; shared with the PWM AXI register block).
REQ-006 pwm_mode_i  in  2  mode: 00 off, 01 fixed duty, 10 breathing, 11 reserved.
REQ-007 pwm_period_i  in  CNT_W  period in clock cycles.
REQ-008 pwm_threshold1_i  in  CNT_W  duty in fixed mode; lower duty bound in breathing mode.
REQ-009 pwm_threshold2_i  in  CNT_W  upper duty bound in breathing mode.
REQ-010 pwm_step_i  in  STEP_W  duty increment/decrement applied per period in breathing mode.
REQ-011 pwm_o  out  1  registered PWM waveform; also returned to the register block's read-only output register.
REQ-012 period_end_o  out  1  one-cycle pulse on the last counter cycle of each period.

Function
REQ-013 Mode 11 SHALL behave identically to mode 00.
REQ-014 In mode 00: counter held at 0, pwm_o=0, period_end_o=0.
REQ-015 A change of pwm_mode_i (compared with its registered copy) SHALL restart the period: next cycle cnt=0, shadows reloaded, breathing duty=threshold1, direction=up.
REQ-016 period, threshold1, threshold2 and step SHALL be captured into shadow registers only at period start (restart or wrap); mid-period input changes SHALL NOT affect the current period.
REQ-017 Counter SHALL count 0..period_sh-1; period_end_o=1 when cnt==period_sh-1; the next cycle cnt=0 and shadows reload.
REQ-018 If period_sh==0: cnt held 0, pwm_o=0, period_end_o=0; shadows reload every cycle so a new non-zero period starts the next cycle.
REQ-019 pwm_o SHALL be registered: pwm_o(t+1) = active && (cnt(t) < duty(t)). Latency is one cycle from counter to output.
REQ-020 In mode 01, duty=threshold1_sh. threshold1=0 gives constant low; threshold1>=period gives constant high.
REQ-021 In mode 10, duty SHALL update once per period, on period_end. Going up: duty=min(duty+step, threshold2_sh); when duty reaches threshold2_sh, direction flips to down. Going down: duty=max(duty-step, threshold1_sh); when duty reaches threshold1_sh, direction flips to up.
REQ-022 Breathing arithmetic SHALL be CNT_W+1 bits wide so it never wraps. step zero-extends to CNT_W.
REQ-023 In mode 10, if threshold1_sh>=threshold2_sh or step==0, duty SHALL remain at threshold1_sh.
REQ-024 Restart and period end in the same cycle: restart wins.

Reset
REQ-025 On reset: cnt=0, pwm_o=0, period_end_o=0, all shadows=0, duty=0, direction=up, registered mode=00.
REQ-026 Reset asserted mid-period SHALL force pwm_o=0 on the next edge. After reset release, operation SHALL start as a mode change if the mode is non-zero.

Structure
REQ-027 Package pwm_pkg SHALL hold the mode encodings (PWM_MODE_OFF/FIXED/BREATH/RSVD) and the default CNT_W/STEP_W values. The package is shared with axi_interface_pwm's successor.
REQ-028 The duty up/down ramp (REQ-021..023) SHALL be a sub-module pwm_breath_ramp: inputs are bounds, step, update strobe and load strobe; output is duty.
REQ-029 Target implementation size: 120-400 lines of RTL, no latches, one clock domain.

Verification
REQ-030 Mode 01, period 10, threshold1 3 -> pwm_o high 3 cycles and low 7, repeating; period_end_o pulses every 10 cycles.
REQ-031 Mode 01, period 10, threshold1 0 -> pwm_o constant 0. threshold1 15 -> pwm_o constant 1. period 0 -> pwm_o 0 and no period_end_o.
REQ-032 Mode 10, period 4, threshold1 1, threshold2 3, step 1 -> per-period high times 1,2,3,2,1,2,3... Step 5 -> 1,3,1,3...
REQ-033 Mode 01, period 10: change threshold1 from 3 to 6 at cnt 2 -> current period keeps 3 high cycles, next period has 6.
REQ-034 Reset asserted at cnt 1 while pwm_o=1 -> pwm_o=0 next edge. Release with mode 01 -> new period starts from cnt 0.
REQ-035 Mode 01 switched to 00 mid-period -> pwm_o=0 within one cycle. Switch back to 01 -> full period from cnt 0.
